mod_counter: RTL and testbench



---
 rtl/mod_counter_pkg.sv | 18 +
 rtl/mod_counter_next.sv | 65 ++++++
 rtl/mod_counter.sv | 75 +++++++
 tb/tb_mod_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod_counter slice.
//   mode_wrap / mode_sat : encodings of the SATURATE parameter.
//   params_legal()       : elaboration-time legality check for WIDTH/MODULUS/RESET_VALUE.
package mod_counter_pkg;

  localparam int unsigned ModeWrap = 0;
  localparam int unsigned ModeSat  = 1;

  // 2 <= modulus <= 2**width and reset_value < modulus; 64-bit math keeps 2**width exact.
  function automatic bit params_legal(input int unsigned width, input int unsigned modulus,
                                      input int unsigned reset_value);
    longint unsigned span;
    span = longint'(64'd1) << width;
    return (width >= 1) && (width <= 31) && (modulus >= 2) &&
           (longint'(modulus) <= span) && (reset_value < modulus);
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state logic for mod_counter.
//   count, up, en, load, load_value : current state and controls
//   next_count : count value for the next edge
//   boundary   : a boundary event happens on this edge (becomes the wrap pulse)
//   set_ovf    : boundary event or out-of-range load
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter int unsigned SATURATE = ModeWrap
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary,
  output logic             set_ovf
);

  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] ModExt = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MaxExt = ModExt - (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] ld_ext;

  assign cnt_ext = {1'b0, count};
  assign ld_ext  = {1'b0, load_value};

  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    set_ovf    = 1'b0;
    if (load) begin
      if (ld_ext < ModExt) begin
        next_count = load_value;
      end else begin
        next_count = WIDTH'(MaxExt);
        set_ovf    = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (cnt_ext == MaxExt) begin
          boundary   = 1'b1;
          set_ovf    = 1'b1;
          next_count = (SATURATE == ModeSat) ? count : '0;
        end else begin
          next_count = WIDTH'(cnt_ext + (WIDTH+1)'(1));
        end
      end else begin
        if (cnt_ext == '0) begin
          boundary   = 1'b1;
          set_ovf    = 1'b1;
          next_count = (SATURATE == ModeSat) ? count : WIDTH'(MaxExt);
        end else begin
          next_count = WIDTH'(cnt_ext - (WIDTH+1)'(1));
        end
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with load, enable, wrap/saturate mode,
// registered boundary pulse and sticky overflow.
//   c          : clock, rising edge
//   reset      : asynchronous active-high reset
//   en, up     : count enable and direction (1 = up)
//   load       : synchronous load of load_value (beats en)
//   clear_ovf  : synchronous overflow clear (a same-cycle set wins)
//   count      : registered count, always in 0..MODULUS-1
//   wrap       : one-cycle pulse alongside the post-boundary count
//   overflow   : sticky boundary / illegal-load flag
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MODULUS     = 256,
  parameter int unsigned SATURATE    = ModeWrap,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             c,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             overflow
);

  if (!params_legal(WIDTH, MODULUS, RESET_VALUE) || (SATURATE > ModeSat)) begin : g_param_err
    $error("mod_counter: illegal WIDTH/MODULUS/RESET_VALUE/SATURATE");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             set_ovf;

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .count     (count_q),
    .up        (up),
    .en        (en),
    .load      (load),
    .load_value(load_value),
    .next_count(count_d),
    .boundary  (wrap_d),
    .set_ovf   (set_ovf)
  );

  always_comb begin
    ovf_d = set_ovf | (ovf_q & ~clear_ovf);
  end

  always_ff @(posedge c or posedge reset) begin
    if (reset) begin
      count_q <= WIDTH'(RESET_VALUE);
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: three instances cover wrap at 2**WIDTH,
// wrap at a non-power-of-two modulus, and saturation with a non-zero reset value.
module tb_mod_counter;

  logic c = 1'b0;
  always #5 c = ~c;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Instance A: WIDTH=3, MODULUS=8, wrap
  logic       a_rst, a_en, a_up, a_ld, a_clr;
  logic [2:0] a_lv, a_cnt;
  logic       a_wrap, a_ovf;

  mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0)) u_a (
    .c(c), .reset(a_rst), .en(a_en), .up(a_up), .load(a_ld), .load_value(a_lv),
    .clear_ovf(a_clr), .count(a_cnt), .wrap(a_wrap), .overflow(a_ovf)
  );

  // Instance B: WIDTH=4, MODULUS=10, wrap
  logic       b_rst, b_en, b_up, b_ld, b_clr;
  logic [3:0] b_lv, b_cnt;
  logic       b_wrap, b_ovf;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) u_b (
    .c(c), .reset(b_rst), .en(b_en), .up(b_up), .load(b_ld), .load_value(b_lv),
    .clear_ovf(b_clr), .count(b_cnt), .wrap(b_wrap), .overflow(b_ovf)
  );

  // Instance S: WIDTH=4, MODULUS=10, saturate, RESET_VALUE=3
  logic       s_rst, s_en, s_up, s_ld, s_clr;
  logic [3:0] s_lv, s_cnt;
  logic       s_wrap, s_ovf;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VALUE(3)) u_s (
    .c(c), .reset(s_rst), .en(s_en), .up(s_up), .load(s_ld), .load_value(s_lv),
    .clear_ovf(s_clr), .count(s_cnt), .wrap(s_wrap), .overflow(s_ovf)
  );

  initial begin
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1; a_ld = 1'b0; a_lv = '0; a_clr = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_lv = '0; b_clr = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_up = 1'b1; s_ld = 1'b0; s_lv = '0; s_clr = 1'b0;

    // Reset state, held through an edge with en=1
    tick();
    check("a_rst_cnt", a_cnt, 0);
    check("a_rst_wrap", a_wrap, 0);
    check("a_rst_ovf", a_ovf, 0);
    check("s_rst_cnt", s_cnt, 3);

    // A: 20 enabled up edges from reset
    @(negedge c);
    a_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("a_cnt_%0d", k), a_cnt, k % 8);
      check($sformatf("a_wrap_%0d", k), a_wrap, (k == 8 || k == 16) ? 1 : 0);
      check($sformatf("a_ovf_%0d", k), a_ovf, (k >= 8) ? 1 : 0);
    end
    a_en = 1'b0;

    // B: illegal load clamps to 9, en/up ignored
    @(negedge c);
    b_rst = 1'b0;
    b_ld = 1'b1; b_lv = 4'd12; b_en = 1'b1; b_up = 1'b0;
    tick();
    check("b_ild_cnt", b_cnt, 9);
    check("b_ild_ovf", b_ovf, 1);
    check("b_ild_wrap", b_wrap, 0);
    b_ld = 1'b0; b_en = 1'b0;

    // B: async reset between edges
    #1 b_rst = 1'b1;
    #1;
    check("b_arst_cnt", b_cnt, 0);
    check("b_arst_ovf", b_ovf, 0);
    @(negedge c);
    b_rst = 1'b0;

    // B: down from 0 wraps to 9
    b_en = 1'b1; b_up = 1'b0;
    tick();
    check("b_dn_cnt0", b_cnt, 9);
    check("b_dn_wrap0", b_wrap, 1);
    check("b_dn_ovf0", b_ovf, 1);
    tick();
    check("b_dn_cnt1", b_cnt, 8);
    check("b_dn_wrap1", b_wrap, 0);

    // B: clear_ovf loses to a same-cycle boundary event
    b_en = 1'b0; b_ld = 1'b1; b_lv = 4'd9;
    tick();
    check("b_ld9_cnt", b_cnt, 9);
    b_ld = 1'b0; b_en = 1'b1; b_up = 1'b1; b_clr = 1'b1;
    tick();
    check("b_clrset_cnt", b_cnt, 0);
    check("b_clrset_wrap", b_wrap, 1);
    check("b_clrset_ovf", b_ovf, 1);
    b_en = 1'b0;
    tick();
    check("b_clr_ovf", b_ovf, 0);
    check("b_clr_cnt", b_cnt, 0);
    check("b_clr_wrap", b_wrap, 0);
    b_clr = 1'b0;
    tick();
    check("b_hold_cnt", b_cnt, 0);

    // S: load 7 then 5 enabled up edges saturate at 9
    @(negedge c);
    s_rst = 1'b0;
    s_ld = 1'b1; s_lv = 4'd7;
    tick();
    check("s_ld7_cnt", s_cnt, 7);
    check("s_ld7_ovf", s_ovf, 0);
    s_ld = 1'b0; s_en = 1'b1; s_up = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("s_cnt_%0d", k), s_cnt, (k == 1) ? 8 : 9);
      check($sformatf("s_wrap_%0d", k), s_wrap, (k >= 3) ? 1 : 0);
    end
    check("s_sat_ovf", s_ovf, 1);

    // S: reset mid-cycle aborts a pending wrap pulse
    #1 s_rst = 1'b1;
    #1;
    check("s_abort_wrap", s_wrap, 0);
    check("s_abort_cnt", s_cnt, 3);
    @(negedge c);
    s_rst = 1'b0; s_en = 1'b0;

    // S: saturate at 0 going down
    s_ld = 1'b1; s_lv = 4'd0;
    tick();
    s_ld = 1'b0; s_en = 1'b1; s_up = 1'b0;
    tick();
    check("s_dn_cnt", s_cnt, 0);
    check("s_dn_wrap", s_wrap, 1);
    check("s_dn_ovf", s_ovf, 1);

    // S: count=5, reset between edges, then resume from RESET_VALUE
    s_en = 1'b0; s_ld = 1'b1; s_lv = 4'd5;
    tick();
    check("s_ld5_cnt", s_cnt, 5);
    s_ld = 1'b0;
    #1 s_rst = 1'b1;
    #1;
    check("s_rst5_cnt", s_cnt, 3);
    check("s_rst5_wrap", s_wrap, 0);
    check("s_rst5_ovf", s_ovf, 0);
    s_en = 1'b1; s_up = 1'b1; s_ld = 1'b1; s_lv = 4'd8;
    tick();
    check("s_rsthold_cnt", s_cnt, 3);
    @(negedge c);
    s_rst = 1'b0; s_ld = 1'b0;
    tick();
    check("s_resume_cnt0", s_cnt, 4);
    tick();
    check("s_resume_cnt1", s_cnt, 5);
    s_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop against any stall in the directed sequence.
  initial begin
    #20000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
